// File: rtl/ycbcr_444_to_422_if.sv
// Stream bundle for the 4:4:4 -> 4:2:2 chroma subsampler: pixel input side and
// interleaved 16-bit output side. Both sides transfer a beat when valid && ready.
interface ycbcr_444_to_422_if;
    logic [7:0]  in_y;
    logic [7:0]  in_cb;
    logic [7:0]  in_cr;
    logic        in_valid;
    logic        in_sof;
    logic        in_eol;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_sof;
    logic        out_eol;
    logic        out_ready;

    // Handshake: a beat moves on a rising clock edge where valid && ready are both
    // high. Valid and its payload must not change until that beat has moved.
    modport master (
        output in_y, in_cb, in_cr, in_valid, in_sof, in_eol, out_ready,
        input  in_ready, out_data, out_valid, out_sof, out_eol
    );

    modport slave (
        input  in_y, in_cb, in_cr, in_valid, in_sof, in_eol, out_ready,
        output in_ready, out_data, out_valid, out_sof, out_eol
    );
endinterface

// File: rtl/ycbcr_444_to_422.sv
// Horizontal chroma subsampler: pairs 4:4:4 pixels into {Cb,Y0},{Cr,Y1} words and
// queues them in a 4-entry FIFO so sink backpressure never drops pixels.
module ycbcr_444_to_422 #(
    parameter int CHROMA_MODE = 0,
    parameter int ROUND       = 1
) (
    input  logic              in_clock,
    input  logic              in_reset,
    ycbcr_444_to_422_if.slave bus,
    output logic              dbg_phase,
    output logic [2:0]        dbg_count
);
    typedef enum logic {EVEN = 1'b0, ODD = 1'b1} phase_t;

    localparam int DEPTH = 4;

    phase_t      phase;
    logic [7:0]  held_y;
    logic [7:0]  held_cb;
    logic [7:0]  held_cr;
    logic        held_sof;

    logic [17:0] mem [DEPTH];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic        ready_en;

    logic        accept;
    logic        pop;
    logic        push;
    logic        new_even;
    logic [7:0]  cb_pair;
    logic [7:0]  cr_pair;
    logic [17:0] word0;
    logic [17:0] word1;

    function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + 9'(ROUND);
        return 8'(s >> 1);
    endfunction

    // in_ready depends only on registers so out_ready never ripples back to the source.
    assign bus.in_ready  = ready_en && (count <= 3'd2);
    assign bus.out_valid = (count != 3'd0);
    assign {bus.out_sof, bus.out_eol, bus.out_data} = mem[rd_ptr];

    assign dbg_phase = (phase == ODD);
    assign dbg_count = count;

    always_comb begin
        accept   = bus.in_valid && bus.in_ready;
        pop      = bus.out_valid && bus.out_ready;
        new_even = (phase == EVEN) || bus.in_sof;
        if (CHROMA_MODE != 0) begin
            cb_pair = held_cb;
            cr_pair = held_cr;
        end else begin
            cb_pair = avg8(held_cb, bus.in_cb);
            cr_pair = avg8(held_cr, bus.in_cr);
        end
        // A lone even pixel at end of line is replicated to complete the pair.
        if (new_even) begin
            push  = accept && bus.in_eol;
            word0 = {bus.in_sof, 1'b0, bus.in_cb, bus.in_y};
            word1 = {1'b0, 1'b1, bus.in_cr, bus.in_y};
        end else begin
            push  = accept;
            word0 = {held_sof, 1'b0, cb_pair, held_y};
            word1 = {1'b0, bus.in_eol, cr_pair, bus.in_y};
        end
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            phase    <= EVEN;
            held_y   <= '0;
            held_cb  <= '0;
            held_cr  <= '0;
            held_sof <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_en <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                mem[wr_ptr]        <= word0;
                mem[wr_ptr + 2'd1] <= word1;
                wr_ptr             <= wr_ptr + 2'd2;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            count <= count + (push ? 3'd2 : 3'd0) - (pop ? 3'd1 : 3'd0);
            // An sof seen mid-pair abandons the held pixel and restarts as even.
            if (accept) begin
                if (new_even) begin
                    held_y   <= bus.in_y;
                    held_cb  <= bus.in_cb;
                    held_cr  <= bus.in_cr;
                    held_sof <= bus.in_sof;
                    phase    <= bus.in_eol ? EVEN : ODD;
                end else begin
                    phase <= EVEN;
                end
            end
        end
    end
endmodule

// File: tb/tb_ycbcr_444_to_422.sv
// Bench for ycbcr_444_to_422: three parameterisations driven by one stimulus
// stream, each checked every cycle against a pair-queue reference model.
module tb_ycbcr_444_to_422;
    typedef struct packed {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
        logic       sof;
    } pix_t;

    logic       clk;
    logic       rst;
    logic [7:0] t_y;
    logic [7:0] t_cb;
    logic [7:0] t_cr;
    logic       t_valid;
    logic       t_sof;
    logic       t_eol;
    logic       man_rdy;
    logic       rnd_rdy;
    logic       bp_mode;
    int         cycle;
    int         checks;
    int         failures;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cycle   <= cycle + 1;
        rnd_rdy <= ($urandom_range(0, 3) != 0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string name, input int ln,
                             input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s lane%0d actual=%0h expected=%0h at cycle %0d",
                     name, ln, act, exp, cycle);
        end
    endtask

    // ---------------- DUT lanes + model + compare ----------------
    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int CM  = (g == 2) ? 1 : 0;
        localparam int RND = (g == 1) ? 0 : 1;

        ycbcr_444_to_422_if ifc();
        logic       dbg_phase;
        logic [2:0] dbg_count;

        assign ifc.in_y      = t_y;
        assign ifc.in_cb     = t_cb;
        assign ifc.in_cr     = t_cr;
        assign ifc.in_valid  = t_valid;
        assign ifc.in_sof    = t_sof;
        assign ifc.in_eol    = t_eol;
        assign ifc.out_ready = bp_mode ? rnd_rdy : man_rdy;

        ycbcr_444_to_422 #(.CHROMA_MODE(CM), .ROUND(RND)) dut (
            .in_clock (clk),
            .in_reset (rst),
            .bus      (ifc),
            .dbg_phase(dbg_phase),
            .dbg_count(dbg_count)
        );

        pix_t        pend[$];
        logic [17:0] exp_q[$];
        logic [17:0] obs_q[$];
        int          obs_t[$];
        bit          started;
        pix_t        p0;
        pix_t        p1;

        function automatic logic [7:0] chroma(input int a, input int b);
            if (CM != 0) return 8'(a);
            return 8'((a + b + RND) / 2);
        endfunction

        always @(negedge clk) begin
            if (rst) begin
                exp_q.delete();
                pend.delete();
                started = 1'b0;
            end else begin
                check_val("in_ready", g, 32'(ifc.in_ready), 32'(started && exp_q.size() <= 2));
                check_val("out_valid", g, 32'(ifc.out_valid), 32'(exp_q.size() != 0));
                check_val("fifo_count", g, 32'(dbg_count), 32'(exp_q.size()));
                check_val("phase_odd", g, 32'(dbg_phase), 32'(pend.size() == 1));
                if (ifc.out_valid && exp_q.size() != 0)
                    check_val("head_word", g, 32'({ifc.out_sof, ifc.out_eol, ifc.out_data}),
                              32'(exp_q[0]));
                if (ifc.out_valid && ifc.out_ready) begin
                    obs_q.push_back({ifc.out_sof, ifc.out_eol, ifc.out_data});
                    obs_t.push_back(cycle);
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
                if (ifc.in_valid && ifc.in_ready) begin
                    if (ifc.in_sof) pend.delete();
                    pend.push_back('{y: ifc.in_y, cb: ifc.in_cb, cr: ifc.in_cr, sof: ifc.in_sof});
                    if (pend.size() == 2) begin
                        p0 = pend[0];
                        p1 = pend[1];
                        exp_q.push_back({p0.sof, 1'b0, chroma(p0.cb, p1.cb), p0.y});
                        exp_q.push_back({1'b0, ifc.in_eol, chroma(p0.cr, p1.cr), p1.y});
                        pend.delete();
                    end else if (ifc.in_eol) begin
                        p0 = pend[0];
                        exp_q.push_back({p0.sof, 1'b0, p0.cb, p0.y});
                        exp_q.push_back({1'b0, 1'b1, p0.cr, p0.y});
                        pend.delete();
                    end
                end
                started = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                        input logic sof, input logic eol);
        int n;
        t_y = y; t_cb = cb; t_cr = cr; t_sof = sof; t_eol = eol; t_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!lane[0].ifc.in_ready && n < 200);
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout in_ready stuck at 0 expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        t_valid = 1'b0;
        t_sof   = 1'b0;
        t_eol   = 1'b0;
    endtask

    task automatic idle(input int n);
        t_valid = 1'b0;
        repeat (n) begin
            t_y = 8'($urandom); t_cb = 8'($urandom); t_cr = 8'($urandom);
            t_sof = 1'($urandom); t_eol = 1'($urandom);
            @(posedge clk);
            #1;
        end
        t_sof = 1'b0;
        t_eol = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((lane[0].exp_q.size() != 0 || lane[1].exp_q.size() != 0 ||
                lane[2].exp_q.size() != 0) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("drain_timeout", 0, 32'(n < 500), 32'd1);
        idle(2);
    endtask

    task automatic clear_obs();
        lane[0].obs_q.delete(); lane[0].obs_t.delete();
        lane[1].obs_q.delete(); lane[1].obs_t.delete();
        lane[2].obs_q.delete(); lane[2].obs_t.delete();
    endtask

    task automatic expect_words(input string name, input int ln, input logic [17:0] got[$],
                                input int n, input logic [17:0] w0, input logic [17:0] w1,
                                input logic [17:0] w2, input logic [17:0] w3);
        logic [17:0] want [4];
        want = '{w0, w1, w2, w3};
        check_val({name, "_count"}, ln, 32'(got.size()), 32'(n));
        for (int i = 0; i < n && i < 4; i++) begin
            if (i < got.size()) check_val({name, "_word"}, ln, 32'(got[i]), 32'(want[i]));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        checks = 0; failures = 0; cycle = 0;
        rst = 1'b1; t_valid = 1'b0; t_sof = 1'b0; t_eol = 1'b0;
        t_y = '0; t_cb = '0; t_cr = '0;
        man_rdy = 1'b1; bp_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_valid", 0, 32'(lane[0].ifc.out_valid), 32'd0);
        check_val("rst_out_data", 0, 32'(lane[0].ifc.out_data), 32'd0);
        check_val("rst_in_ready", 0, 32'(lane[0].ifc.in_ready), 32'd0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("ready_after_rst", 0, 32'(lane[0].ifc.in_ready), 32'd1);

        // average pair, all three chroma settings
        clear_obs();
        send(8'd10, 8'd100, 8'd200, 1'b1, 1'b0);
        send(8'd20, 8'd101, 8'd50, 1'b0, 1'b1);
        drain();
        expect_words("avg_r1", 0, lane[0].obs_q, 2, 18'h2650A, 18'h17D14, 18'h0, 18'h0);
        expect_words("avg_r0", 1, lane[1].obs_q, 2, 18'h2640A, 18'h17D14, 18'h0, 18'h0);
        expect_words("cosite", 2, lane[2].obs_q, 2, 18'h2640A, 18'h1C814, 18'h0, 18'h0);
        if (lane[0].obs_t.size() >= 2)
            check_val("back_to_back", 0, 32'(lane[0].obs_t[1] - lane[0].obs_t[0]), 32'd1);

        // extreme chroma values
        clear_obs();
        send(8'd16, 8'd255, 8'd0, 1'b1, 1'b0);
        send(8'd235, 8'd0, 8'd255, 1'b0, 1'b1);
        drain();
        expect_words("ext_r1", 0, lane[0].obs_q, 2, 18'h28010, 18'h180EB, 18'h0, 18'h0);
        expect_words("ext_r0", 1, lane[1].obs_q, 2, 18'h27F10, 18'h17FEB, 18'h0, 18'h0);
        expect_words("ext_cs", 2, lane[2].obs_q, 2, 18'h2FF10, 18'h100EB, 18'h0, 18'h0);

        // odd-length line replicates the last pixel
        clear_obs();
        send(8'd1, 8'd10, 8'd20, 1'b0, 1'b0);
        send(8'd3, 8'd30, 8'd40, 1'b0, 1'b0);
        send(8'd5, 8'd50, 8'd60, 1'b0, 1'b1);
        drain();
        expect_words("odd_r1", 0, lane[0].obs_q, 4, 18'h01401, 18'h01E03, 18'h03205, 18'h13C05);
        expect_words("odd_cs", 2, lane[2].obs_q, 4, 18'h00A01, 18'h01403, 18'h03205, 18'h13C05);

        // sof mid-pair drops the held even pixel
        clear_obs();
        send(8'd50, 8'd60, 8'd70, 1'b0, 1'b0);
        send(8'd80, 8'd90, 8'd100, 1'b1, 1'b0);
        send(8'd110, 8'd120, 8'd130, 1'b0, 1'b1);
        drain();
        expect_words("restart", 0, lane[0].obs_q, 2, 18'h26950, 18'h1736E, 18'h0, 18'h0);

        // backpressure: sink stalls for 6 cycles under an 8-pixel ramp
        clear_obs();
        man_rdy = 1'b0;
        fork
            begin
                repeat (6) @(posedge clk);
                #1 man_rdy = 1'b1;
            end
        join_none
        for (int i = 0; i < 8; i++) begin
            send(8'(i * 10), 8'(50 + i), 8'(200 - i * 3), 1'(i == 0), 1'(i == 7));
            if (i == 3) check_val("stall_in_ready", 0, 32'(lane[0].ifc.in_ready), 32'd0);
        end
        drain();
        check_val("ramp_count", 0, 32'(lane[0].obs_q.size()), 32'd8);
        if (lane[0].obs_q.size() == 8) begin
            check_val("ramp_first", 0, 32'(lane[0].obs_q[0]), 32'h23300);
            check_val("ramp_w6", 0, 32'(lane[0].obs_q[6]), 32'h0393C);
            check_val("ramp_last", 0, 32'(lane[0].obs_q[7]), 32'h1B546);
        end

        // async reset with two words queued and an even pixel held
        clear_obs();
        man_rdy = 1'b0;
        send(8'd1, 8'd2, 8'd3, 1'b1, 1'b0);
        send(8'd4, 8'd5, 8'd6, 1'b0, 1'b1);
        send(8'd7, 8'd8, 8'd9, 1'b0, 1'b0);
        check_val("pre_rst_valid", 0, 32'(lane[0].ifc.out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("arst_out_valid", 0, 32'(lane[0].ifc.out_valid), 32'd0);
        check_val("arst_out_data", 0, 32'(lane[0].ifc.out_data), 32'd0);
        check_val("arst_out_sof", 0, 32'(lane[0].ifc.out_sof), 32'd0);
        check_val("arst_out_eol", 0, 32'(lane[0].ifc.out_eol), 32'd0);
        check_val("arst_in_ready", 0, 32'(lane[0].ifc.in_ready), 32'd0);
        check_val("arst_out_valid", 2, 32'(lane[2].ifc.out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        man_rdy = 1'b1;
        send(8'd10, 8'd100, 8'd200, 1'b1, 1'b0);
        send(8'd20, 8'd101, 8'd50, 1'b0, 1'b1);
        drain();
        expect_words("post_rst", 0, lane[0].obs_q, 2, 18'h2650A, 18'h17D14, 18'h0, 18'h0);

        // randomized frames with random sink backpressure and source gaps
        bp_mode = 1'b1;
        for (int f = 0; f < 6; f++) begin
            int nl;
            nl = $urandom_range(1, 3);
            for (int l = 0; l < nl; l++) begin
                int len;
                len = $urandom_range(1, 9);
                for (int p = 0; p < len; p++) begin
                    logic sof;
                    sof = ((l == 0) && (p == 0)) || ($urandom_range(0, 11) == 0);
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                    send(8'($urandom), 8'($urandom), 8'($urandom), sof, 1'(p == len - 1));
                end
            end
        end
        bp_mode = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
